img_diff_packer: RTL
====================

// Module: img_diff_packer
// PURPOSE
//  Downstream of the frame-difference stage: thresholds each 8-bit pixel of the 32-bit diff stream,
//  frames words into AXI4-Stream (tuser=SOF, tlast=EOF), buffers in a FIFO for a back-pressuring sink,
//  and reports a per-frame count of pixels over threshold. Upstream port has no ready; overflow drops.
// PARAMETERS
//  FRAME_WORDS  262144  32-bit words per frame (sim override 8)
//  FIFO_DEPTH   16      output FIFO entries, power of 2, >=4
//  CNT_W        21      width of frame_pix_cnt (holds 4*FRAME_WORDS)
// PORTS
//  clk             in   1      clock, all logic rising edge
//  rst             in   1      asynchronous reset, active-high
//  frame_start     in   1      level; rising edge marks a new frame
//  thresh_en       in   1      1=binarize, 0=pass data through unchanged
//  thresh          in   8      pixel threshold, latched at frame start
//  data_in         in   32     4 pixels, [7:0] = first pixel
//  data_in_valid   in   1      data_in qualifier, no backpressure
//  m_axis_tdata    out  32     output pixels
//  m_axis_tvalid   out  1      output valid
//  m_axis_tready   in   1      sink ready
//  m_axis_tuser    out  1      1 on word 0 of a frame
//  m_axis_tlast    out  1      1 on word FRAME_WORDS-1
//  frame_pix_cnt   out  CNT_W  pixels >= thresh in last completed frame
//  frame_cnt_valid out  1      1-cycle pulse when frame_pix_cnt updates
//  clr_err         in   1      synchronous clear of sticky flags
//  overflow        out  1      sticky: word dropped on FIFO full
//  frame_short     out  1      sticky: frame_start rise before frame completed
//  stray_data      out  1      sticky: valid word received while IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, counters 0, thresh latch 0, frame_start_d 0.
//  rise = frame_start & ~frame_start_d (frame_start_d registered each cycle).
//  FSM IDLE/RUN/DONE:
//   IDLE: rise -> RUN; latch thresh, thresh_en; word_cnt=0, pix_acc=0. Valid words dropped, stray_data=1
//    (except a word on the rise cycle, which is word 0 of the new frame).
//   RUN: each valid word: word_cnt++, pix_acc += hits. Word FRAME_WORDS-1 -> DONE.
//    rise in RUN: frame_short=1, counters restart, re-latch thresh; aborted frame gets no tlast,
//    no count publish; word on rise cycle is word 0 of new frame.
//   DONE (1 cycle): frame_pix_cnt <= final pix_acc, frame_cnt_valid=1 -> IDLE. rise in DONE handled as IDLE.
//  Threshold per byte: thresh_en ? (pix>=thresh ? 8'hFF : 8'h00) : pix. hits = number of bytes with
//   pix>=thresh (counted even when thresh_en=0). Unsigned compare; thresh=0 -> all pixels hit.
//  Pipeline: input sampled edge k -> stage reg edge k+1 -> FIFO write edge k+2 -> tvalid visible after
//   k+2 when FIFO empty (latency 2). tuser/tlast computed from word_cnt at stage 1, travel with data.
//  frame_cnt_valid pulses in the cycle after the last word's stage-1 edge (same edge as its FIFO write).
//  FIFO: first-word-fall-through, entry = {tuser,tlast,tdata}. Pop on tvalid&tready. Write when full is
//   dropped (read in same cycle does not rescue it), overflow=1; word/pixel counts still include it.
//  AXI: tdata/tuser/tlast stable while tvalid&~tready; tvalid never drops without a handshake.
//  Sticky flags clear only on rst or clr_err (clr_err wins over a same-cycle set -> flag 0).
//  Async reset mid-frame: FIFO contents lost, tvalid 0 immediately, no count published.
// TESTING (FRAME_WORDS=8, FIFO_DEPTH=16)
//  1 rise, thresh=0x10, thresh_en=1, 8 words 0x20_0F_10_00, tready=1 -> tdata 0xFF_00_FF_00 x8,
//    tuser on #0, tlast on #7, frame_pix_cnt=16, frame_cnt_valid 1 cycle, first tvalid 2 cycles after word 0.
//  2 thresh_en=0, words 0x01020304.. -> data passes unchanged; count still per thresh; tuser/tlast correct.
//  3 tready=0 for 20 words across 3 frames -> 16 held, overflow=1, frame_pix_cnt still correct;
//    release tready -> 16 words out in order, stable while stalled.
//  4 rise after 5 words -> frame_short=1, no tlast/count for frame A; next 8 words framed normally;
//    clr_err -> frame_short=0.
//  5 valid words before any rise -> dropped, stray_data=1, tvalid stays 0.
//  6 rst asserted with 6 words queued -> tvalid=0 same cycle, all outputs 0, next frame normal.

Source files
------------

// File: rtl/img_diff_packer.sv
// img_diff_packer
//   Thresholds each byte of a 32-bit frame-difference word, frames the words
//   into AXI4-Stream (tuser = first word, tlast = last word) and buffers them
//   in a first-word-fall-through FIFO for a sink that can stall. Also reports
//   the number of pixels at or above threshold for each completed frame.
//   The upstream side has no ready: a word arriving when the FIFO is full is
//   dropped and flagged.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   frame_start              level; a rising edge starts a new frame
//   thresh_en, thresh        binarize enable and threshold, latched on the rise
//   data_in, data_in_valid   4 pixels per word ([7:0] first), no backpressure
//   m_axis_*                 AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   frame_pix_cnt            hit count of the last completed frame
//   frame_cnt_valid          1-cycle pulse when frame_pix_cnt updates
//   clr_err                  synchronous clear of the sticky flags
//   overflow                 sticky: word dropped because the FIFO was full
//   frame_short              sticky: new frame started before the last finished
//   stray_data               sticky: valid word seen outside a frame
//
// state | meaning
// IDLE  | no frame active; valid words are dropped as stray
// RUN   | counting words of the current frame
// DONE  | one cycle: publish the frame hit count, then back to IDLE
module img_diff_packer #(
    parameter int FRAME_WORDS = 262144,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             thresh_en,
    input  logic [7:0]       thresh,
    input  logic [31:0]      data_in,
    input  logic             data_in_valid,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] frame_pix_cnt,
    output logic             frame_cnt_valid,
    input  logic             clr_err,
    output logic             overflow,
    output logic             frame_short,
    output logic             stray_data
);

    localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic              frame_start_d;
    logic [7:0]        thresh_q;
    logic              thresh_en_q;
    logic [WC_W-1:0]   word_cnt;
    logic [CNT_W-1:0]  pix_acc;

    logic              stage_valid;
    logic [31:0]       stage_data;
    logic              stage_user;
    logic              stage_last;

    logic [33:0]       mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [33:0]       rd_word;

    logic              rise;
    logic              accept;
    logic [7:0]        eff_thresh;
    logic              eff_en;
    logic [WC_W-1:0]   wc_cur;
    logic [CNT_W-1:0]  acc_cur;
    logic              word_first;
    logic              word_last;
    logic [2:0]        hits;
    logic [31:0]       thr_data;
    logic              short_set;
    logic              stray_set;
    logic              ovf_set;

    // A word arriving on the rise cycle belongs to the new frame, so it must
    // see the new threshold and restarted counters rather than the latched ones.
    assign rise       = frame_start & ~frame_start_d;
    assign accept     = data_in_valid & (rise | (state == RUN));
    assign eff_thresh = rise ? thresh    : thresh_q;
    assign eff_en     = rise ? thresh_en : thresh_en_q;
    assign wc_cur     = rise ? '0 : word_cnt;
    assign acc_cur    = rise ? '0 : pix_acc;
    assign word_first = (wc_cur == '0);
    assign word_last  = (wc_cur == WC_W'(FRAME_WORDS - 1));

    assign short_set  = rise & (state == RUN);
    assign stray_set  = data_in_valid & ~rise & (state != RUN);
    assign ovf_set    = stage_valid & fifo_full;

    always_comb begin
        hits     = '0;
        thr_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (data_in[8*i +: 8] >= eff_thresh) begin
                hits = hits + 3'd1;
                thr_data[8*i +: 8] = eff_en ? 8'hFF : data_in[8*i +: 8];
            end else begin
                thr_data[8*i +: 8] = eff_en ? 8'h00 : data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            frame_start_d   <= 1'b0;
            thresh_q        <= '0;
            thresh_en_q     <= 1'b0;
            word_cnt        <= '0;
            pix_acc         <= '0;
            frame_pix_cnt   <= '0;
            frame_cnt_valid <= 1'b0;
            stage_valid     <= 1'b0;
            stage_data      <= '0;
            stage_user      <= 1'b0;
            stage_last      <= 1'b0;
            overflow        <= 1'b0;
            frame_short     <= 1'b0;
            stray_data      <= 1'b0;
        end else begin
            frame_start_d   <= frame_start;
            frame_cnt_valid <= 1'b0;
            stage_valid     <= accept;
            if (accept) begin
                stage_data <= thr_data;
                stage_user <= word_first;
                stage_last <= word_last;
            end
            if (rise) begin
                thresh_q    <= thresh;
                thresh_en_q <= thresh_en;
            end
            // Publish uses the finished frame's total even if a new frame
            // restarts pix_acc on this same edge.
            if (state == DONE) begin
                frame_pix_cnt   <= pix_acc;
                frame_cnt_valid <= 1'b1;
            end
            if (rise || state == RUN) begin
                if (accept) begin
                    word_cnt <= wc_cur + WC_W'(1);
                    pix_acc  <= acc_cur + CNT_W'(hits);
                    state    <= word_last ? DONE : RUN;
                end else begin
                    word_cnt <= wc_cur;
                    pix_acc  <= acc_cur;
                    state    <= RUN;
                end
            end else begin
                state <= IDLE;
            end
            overflow    <= ~clr_err & (overflow    | ovf_set);
            frame_short <= ~clr_err & (frame_short | short_set);
            stray_data  <= ~clr_err & (stray_data  | stray_set);
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle does not make room for a write to a full FIFO.
    assign push       = stage_valid & ~fifo_full;
    assign pop        = ~fifo_empty & m_axis_tready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {stage_user, stage_last, stage_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset, so the outputs are forced to 0 while empty.
    assign rd_word       = mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0   : rd_word[31:0];
    assign m_axis_tlast  = fifo_empty ? 1'b0 : rd_word[32];
    assign m_axis_tuser  = fifo_empty ? 1'b0 : rd_word[33];

endmodule
